// File: rtl/audio_adc_receiver_pkg.sv
// Shared definitions for the WM8731 I2S ADC receive path: default sample width,
// LRCK channel polarity and the receive FSM state encoding.
package audio_adc_receiver_pkg;

    localparam int AUDIO_DATA_WIDTH = 16;
    localparam logic LRCK_LEFT = 1'b0;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_DELAY_L,
        ST_SHIFT_L,
        ST_PAD_L,
        ST_DELAY_R,
        ST_SHIFT_R,
        ST_PAD_R
    } rx_state_t;

endpackage

// File: rtl/audio_adc_receiver_i2s_edge_sync.sv
// Multi-flop synchroniser for one asynchronous codec pin, with one-clk rise/fall
// strobes derived from the synchronised level.
module i2s_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/audio_adc_receiver.sv
// I2S receiver for the WM8731 ADC: oversamples BCLK/ADCLRCK/ADCDAT and publishes stereo frames
// over valid/ready. Define AUD_RX_LEVEL_EN to add the 4-bit left-channel peak meter output.
module audio_adc_receiver
    import audio_adc_receiver_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_ADCLRCK,
    input  logic                  AUD_ADCDAT,
    input  logic                  sample_ready,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  overrun
`ifdef AUD_RX_LEVEL_EN
    ,
    output logic [3:0]            level
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic bclk_lvl, bclk_rise, bclk_fall;
    logic lrck_lvl, lrck_rise, lrck_fall;
    logic dat_lvl, dat_rise, dat_fall;
    logic unused_sync;

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk(clk), .rst_n(rst_n), .din(AUD_BCLK),
        .level(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall)
    );

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk(clk), .rst_n(rst_n), .din(AUD_ADCLRCK),
        .level(lrck_lvl), .rise(lrck_rise), .fall(lrck_fall)
    );

    i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
        .clk(clk), .rst_n(rst_n), .din(AUD_ADCDAT),
        .level(dat_lvl), .rise(dat_rise), .fall(dat_fall)
    );

    // LRCK and data only matter at BCLK rises, so their own strobes go unused.
    assign unused_sync = &{1'b0, bclk_lvl, bclk_fall, lrck_rise, lrck_fall, dat_rise, dat_fall};

    rx_state_t             state, state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] left_sr, right_sr;
    logic                  lrck_prev;
    logic                  left_ok;
    logic                  publish_q;
    logic                  lrck_edge, lrck_to_left, last_bit, publish;

    assign lrck_edge    = bclk_rise & (lrck_lvl != lrck_prev);
    assign lrck_to_left = lrck_edge & (lrck_lvl == LRCK_LEFT);
    assign last_bit     = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign publish      = bclk_rise & ~lrck_edge & (state == ST_SHIFT_R) & last_bit & left_ok;

    // Any LRCK edge re-aligns to the matching DELAY state, which also discards short words.
    always_comb begin
        state_nxt = state;
        if (bclk_rise) begin
            if (lrck_edge) begin
                if (lrck_to_left) begin
                    state_nxt = ST_DELAY_L;
                end else if (state != ST_SYNC) begin
                    state_nxt = ST_DELAY_R;
                end
            end else begin
                case (state)
                    ST_DELAY_L: state_nxt = ST_SHIFT_L;
                    ST_SHIFT_L: if (last_bit) state_nxt = ST_PAD_L;
                    ST_DELAY_R: state_nxt = ST_SHIFT_R;
                    ST_SHIFT_R: if (last_bit) state_nxt = ST_PAD_R;
                    default:    state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SYNC;
            bit_cnt   <= '0;
            left_sr   <= '0;
            right_sr  <= '0;
            lrck_prev <= 1'b0;
            left_ok   <= 1'b0;
            publish_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            publish_q <= publish;
            if (bclk_rise) begin
                lrck_prev <= lrck_lvl;
                if (!lrck_edge) begin
                    case (state)
                        ST_DELAY_L, ST_DELAY_R: bit_cnt <= '0;
                        ST_SHIFT_L: begin
                            left_sr <= {left_sr[DATA_WIDTH-2:0], dat_lvl};
                            if (!last_bit) bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                        ST_SHIFT_R: begin
                            right_sr <= {right_sr[DATA_WIDTH-2:0], dat_lvl};
                            if (!last_bit) bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                        default: ;
                    endcase
                end
                // A frame may only publish if its left word completed since the last 1->0 edge.
                if (lrck_to_left) begin
                    left_ok <= 1'b0;
                end else if (!lrck_edge && state == ST_SHIFT_L && last_bit) begin
                    left_ok <= 1'b1;
                end
            end
        end
    end

    // Publishing always wins over acceptance, so the newest frame is the one held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (publish_q) begin
                left_data    <= left_sr;
                right_data   <= right_sr;
                sample_valid <= 1'b1;
                overrun      <= sample_valid & ~sample_ready;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef AUD_RX_LEVEL_EN
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH-1:0] left_abs;
    logic [DATA_WIDTH-1:0] peak;
    logic [19:0]           decay_cnt;

    // The most negative sample has no positive counterpart, so it saturates.
    always_comb begin
        left_abs = left_sr;
        if (left_sr[DATA_WIDTH-1]) begin
            if (left_sr == ~MAX_POS) begin
                left_abs = MAX_POS;
            end else begin
                left_abs = ~left_sr + DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak      <= '0;
            decay_cnt <= '0;
        end else begin
            decay_cnt <= decay_cnt + 20'd1;
            if (publish_q && left_abs > peak) begin
                peak <= left_abs;
            end else if (decay_cnt == '1) begin
                peak <= peak - (peak >> 4);
            end
        end
    end

    assign level = peak[DATA_WIDTH-2 -: 4];
`endif

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Self-checking bench for audio_adc_receiver: random I2S frames against a frame-level
// reference model of which frames must be published.
module tb_audio_adc_receiver;

    localparam int DW        = 16;
    localparam int SS        = 2;
    localparam int HALF_CLKS = 8;
    localparam int FULL      = DW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT;
    logic          sample_ready;
    logic [DW-1:0] left_data, right_data;
    logic          sample_valid, overrun;
`ifdef AUD_RX_LEVEL_EN
    logic [3:0]    level;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] got_l[$], got_r[$], exp_l[$], exp_r[$];
    int   ovr_cnt        = 0;
    int   valid_rise_cnt = 0;
    int   valid_rise_cyc = 0;
    int   last_rbit_cyc  = 0;
    logic valid_d        = 1'b0;

    logic          model_prev_lr;
    logic          model_left_good;
    logic [DW-1:0] model_left;

    audio_adc_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .AUD_BCLK(AUD_BCLK),
        .AUD_ADCLRCK(AUD_ADCLRCK),
        .AUD_ADCDAT(AUD_ADCDAT),
        .sample_ready(sample_ready),
        .left_data(left_data),
        .right_data(right_data),
        .sample_valid(sample_valid),
        .overrun(overrun)
`ifdef AUD_RX_LEVEL_EN
        ,
        .level(level)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observes accepted frames, overrun pulses and valid rising edges away from the active edge.
    always @(negedge clk) begin
        valid_d <= sample_valid;
        if (rst_n) begin
            if (sample_valid && sample_ready) begin
                got_l.push_back(left_data);
                got_r.push_back(right_data);
            end
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (sample_valid && !valid_d) begin
                valid_rise_cnt <= valid_rise_cnt + 1;
                valid_rise_cyc <= cyc;
            end
        end
    end

    task automatic bclk_bit(input logic lr, input logic d, input bit mark);
        @(negedge clk);
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = lr;
        AUD_ADCDAT  = d;
        repeat (HALF_CLKS) @(negedge clk);
        AUD_BCLK = 1'b1;
        if (mark) last_rbit_cyc = cyc;
        repeat (HALF_CLKS - 1) @(negedge clk);
    endtask

    // One LRCK half-frame of n BCLKs; the word sits on rises 2..DW+1, everything else is junk.
    task automatic send_half(input logic lr, input int n, input logic [DW-1:0] word);
        logic d;
        for (int k = 0; k < n; k++) begin
            if (k >= 2 && k < FULL) d = word[FULL-1-k];
            else d = 1'($urandom);
            bclk_bit(lr, d, (lr == 1'b1) && (k == FULL - 1));
        end
        if (lr == 1'b0) begin
            model_left_good = (model_prev_lr == 1'b1) && (n >= FULL);
            model_left      = word;
        end else begin
            if (model_left_good && n >= FULL) begin
                exp_l.push_back(model_left);
                exp_r.push_back(word);
            end
            model_left_good = 1'b0;
        end
        model_prev_lr = lr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        AUD_BCLK    = 1'b0;
        AUD_ADCLRCK = 1'b0;
        AUD_ADCDAT  = 1'b0;
        model_prev_lr   = 1'b0;
        model_left_good = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        AUD_BCLK     = 1'($urandom);
        AUD_ADCLRCK  = 1'($urandom);
        AUD_ADCDAT   = 1'($urandom);
        sample_ready = 1'($urandom);
        rst_n        = 1'b0;
        #1;
        checks++; if (left_data !== '0) begin failures++; $display("[TB] FAIL reset_left got=%h exp=0", left_data); end
        checks++; if (right_data !== '0) begin failures++; $display("[TB] FAIL reset_right got=%h exp=0", right_data); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
        do_reset();
        repeat (20) @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid got=%b exp=0", sample_valid); end
    endtask

    task automatic test_basic();
        int g0, e0, v0, ng, ne;
        do_reset();
        sample_ready = 1'b1;
        g0 = got_l.size(); e0 = exp_l.size(); v0 = valid_rise_cnt;
        send_half(1'b1, 20, '0);
        send_half(1'b0, 32, 16'h8001);
        send_half(1'b1, 32, 16'h7FFE);
        checks++;
        if (valid_rise_cyc - last_rbit_cyc !== SS + 2) begin
            failures++;
            $display("[TB] FAIL basic_latency got=%0d exp=%0d", valid_rise_cyc - last_rbit_cyc, SS + 2);
        end
        for (int f = 0; f < 3; f++) begin
            send_half(1'b0, 32, DW'($urandom));
            send_half(1'b1, 32, DW'($urandom));
        end
        repeat (10) @(negedge clk);
        ng = got_l.size() - g0; ne = exp_l.size() - e0;
        checks++; if (ng !== ne) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=%0d", ng, ne); end
        checks++;
        if (valid_rise_cnt - v0 !== ne) begin
            failures++; $display("[TB] FAIL basic_pulses got=%0d exp=%0d", valid_rise_cnt - v0, ne);
        end
        for (int i = 0; i < ne && i < ng; i++) begin
            checks++;
            if ({got_l[g0+i], got_r[g0+i]} !== {exp_l[e0+i], exp_r[e0+i]}) begin
                failures++;
                $display("[TB] FAIL basic_frame%0d got=%h/%h exp=%h/%h", i, got_l[g0+i], got_r[g0+i], exp_l[e0+i], exp_r[e0+i]);
            end
        end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_drop got=%b exp=0", sample_valid); end
    endtask

    task automatic test_mid_start();
        int g0, e0, ng, ne;
        for (int s = 0; s < 2; s++) begin
            do_reset();
            sample_ready = 1'b1;
            g0 = got_l.size(); e0 = exp_l.size();
            send_half(s[0], 7 + s * 3, DW'($urandom));
            for (int f = 0; f < 3; f++) begin
                send_half(1'b0, 32, DW'($urandom));
                send_half(1'b1, 32, DW'($urandom));
            end
            repeat (10) @(negedge clk);
            ng = got_l.size() - g0; ne = exp_l.size() - e0;
            checks++; if (ng !== ne) begin failures++; $display("[TB] FAIL mid%0d_count got=%0d exp=%0d", s, ng, ne); end
            for (int i = 0; i < ne && i < ng; i++) begin
                checks++;
                if ({got_l[g0+i], got_r[g0+i]} !== {exp_l[e0+i], exp_r[e0+i]}) begin
                    failures++;
                    $display("[TB] FAIL mid%0d_frame%0d got=%h/%h exp=%h/%h", s, i, got_l[g0+i], got_r[g0+i], exp_l[e0+i], exp_r[e0+i]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int g0, e0, o0, ne;
        do_reset();
        sample_ready = 1'b0;
        g0 = got_l.size(); e0 = exp_l.size(); o0 = ovr_cnt;
        send_half(1'b1, 20, '0);
        for (int f = 1; f <= 3; f++) begin
            send_half(1'b0, 32, DW'(f));
            send_half(1'b1, 32, DW'($urandom));
        end
        ne = exp_l.size() - e0;
        checks++; if (ovr_cnt - o0 !== ne - 1) begin failures++; $display("[TB] FAIL ovr_pulses got=%0d exp=%0d", ovr_cnt - o0, ne - 1); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovr_valid_held got=%b exp=1", sample_valid); end
        checks++;
        if ({left_data, right_data} !== {exp_l[exp_l.size()-1], exp_r[exp_r.size()-1]}) begin
            failures++;
            $display("[TB] FAIL ovr_held_data got=%h/%h exp=%h/%h", left_data, right_data, exp_l[exp_l.size()-1], exp_r[exp_r.size()-1]);
        end
        @(posedge clk); #1 sample_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovr_valid_drop got=%b exp=0", sample_valid); end
        checks++;
        if (got_l.size() - g0 !== 1) begin
            failures++; $display("[TB] FAIL ovr_accepts got=%0d exp=1", got_l.size() - g0);
        end else if (got_l[g0] !== exp_l[exp_l.size()-1]) begin
            failures++; $display("[TB] FAIL ovr_accepted got=%h exp=%h", got_l[g0], exp_l[exp_l.size()-1]);
        end
    endtask

    task automatic test_long_half();
        int g0, e0, ng, ne;
        do_reset();
        sample_ready = 1'b1;
        g0 = got_l.size(); e0 = exp_l.size();
        send_half(1'b1, 24, '0);
        send_half(1'b0, 24, 16'hA5A5);
        send_half(1'b1, 24, DW'($urandom));
        send_half(1'b0, 24, DW'($urandom));
        send_half(1'b1, 24, DW'($urandom));
        repeat (10) @(negedge clk);
        ng = got_l.size() - g0; ne = exp_l.size() - e0;
        checks++; if (ng !== ne) begin failures++; $display("[TB] FAIL long_count got=%0d exp=%0d", ng, ne); end
        for (int i = 0; i < ne && i < ng; i++) begin
            checks++;
            if ({got_l[g0+i], got_r[g0+i]} !== {exp_l[e0+i], exp_r[e0+i]}) begin
                failures++;
                $display("[TB] FAIL long_frame%0d got=%h/%h exp=%h/%h", i, got_l[g0+i], got_r[g0+i], exp_l[e0+i], exp_r[e0+i]);
            end
        end
    endtask

    task automatic test_short_word();
        int g0, e0, ng, ne;
        do_reset();
        sample_ready = 1'b1;
        g0 = got_l.size(); e0 = exp_l.size();
        send_half(1'b1, 20, '0);
        send_half(1'b0, 32, DW'($urandom)); send_half(1'b1, 32, DW'($urandom));
        send_half(1'b0, 12, DW'($urandom)); send_half(1'b1, 32, DW'($urandom));
        send_half(1'b0, 32, DW'($urandom)); send_half(1'b1, 12, DW'($urandom));
        send_half(1'b0, 32, DW'($urandom)); send_half(1'b1, 32, DW'($urandom));
        repeat (10) @(negedge clk);
        ng = got_l.size() - g0; ne = exp_l.size() - e0;
        checks++; if (ng !== ne) begin failures++; $display("[TB] FAIL short_count got=%0d exp=%0d", ng, ne); end
        for (int i = 0; i < ne && i < ng; i++) begin
            checks++;
            if ({got_l[g0+i], got_r[g0+i]} !== {exp_l[e0+i], exp_r[e0+i]}) begin
                failures++;
                $display("[TB] FAIL short_frame%0d got=%h/%h exp=%h/%h", i, got_l[g0+i], got_r[g0+i], exp_l[e0+i], exp_r[e0+i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g0, e0, ng, ne;
        do_reset();
        sample_ready = 1'b0;
        send_half(1'b1, 20, '0);
        send_half(1'b0, 32, 16'h1234); send_half(1'b1, 32, 16'h4321);
        send_half(1'b0, 32, DW'($urandom)); send_half(1'b1, 8, DW'($urandom));
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("[TB] FAIL rmid_pre_valid got=%b exp=1", sample_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_valid got=%b exp=0", sample_valid); end
        checks++; if (left_data !== '0) begin failures++; $display("[TB] FAIL rmid_left got=%h exp=0", left_data); end
        checks++; if (right_data !== '0) begin failures++; $display("[TB] FAIL rmid_right got=%h exp=0", right_data); end
        @(negedge clk);
        AUD_BCLK = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_prev_lr   = 1'b0;
        model_left_good = 1'b0;
        sample_ready    = 1'b1;
        g0 = got_l.size(); e0 = exp_l.size();
        send_half(1'b1, 10, DW'($urandom));
        for (int f = 0; f < 2; f++) begin
            send_half(1'b0, 32, DW'($urandom));
            send_half(1'b1, 32, DW'($urandom));
        end
        repeat (10) @(negedge clk);
        ng = got_l.size() - g0; ne = exp_l.size() - e0;
        checks++; if (ng !== ne) begin failures++; $display("[TB] FAIL rmid_count got=%0d exp=%0d", ng, ne); end
        for (int i = 0; i < ne && i < ng; i++) begin
            checks++;
            if ({got_l[g0+i], got_r[g0+i]} !== {exp_l[e0+i], exp_r[e0+i]}) begin
                failures++;
                $display("[TB] FAIL rmid_frame%0d got=%h/%h exp=%h/%h", i, got_l[g0+i], got_r[g0+i], exp_l[e0+i], exp_r[e0+i]);
            end
        end
    endtask

`ifdef AUD_RX_LEVEL_EN
    task automatic test_level();
        do_reset();
        sample_ready = 1'b1;
        send_half(1'b1, 20, '0);
        send_half(1'b0, 32, 16'h7FFF);
        send_half(1'b1, 32, '0);
        checks++; if (level !== 4'hF) begin failures++; $display("[TB] FAIL level_peak got=%h exp=f", level); end
    endtask
`endif

    initial begin
        rst_n           = 1'b0;
        AUD_BCLK        = 1'b0;
        AUD_ADCLRCK     = 1'b0;
        AUD_ADCDAT      = 1'b0;
        sample_ready    = 1'b0;
        model_prev_lr   = 1'b0;
        model_left_good = 1'b0;
        model_left      = '0;
        test_reset();
        test_basic();
        test_mid_start();
        test_overrun();
        test_long_half();
        test_short_word();
        test_reset_mid();
`ifdef AUD_RX_LEVEL_EN
        test_level();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
